// File: rtl/ff_load_arbiter_pkg.sv
// ff_load_arbiter_pkg: shared state encoding and width helper for the load arbiter
package ff_load_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, HOLD = 2'd2} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/ff_load_arbiter_if.sv
// ff_load_arbiter_if: requester-side bus of the shared register arbiter
interface ff_load_arbiter_if #(parameter int NREQ = 4, parameter int WIDTH = 8);
  import ff_load_arbiter_pkg::*;
  localparam int PW = clog2(NREQ);
  logic [NREQ-1:0] req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0] ack;
  logic [WIDTH-1:0] q;
  logic [PW-1:0] owner;
  logic busy;
  modport master(output req, wdata, input ack, q, owner, busy);
  modport slave(input req, wdata, output ack, q, owner, busy);
endinterface

// File: rtl/ff_load_arbiter_en_reg.sv
// ff_en_reg: WIDTH-bit register with synchronous reset and clock-enable
module ff_en_reg #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/ff_load_arbiter.sv
// ff_load_arbiter: round-robin sequencer loading one requester at a time into a shared register
module ff_load_arbiter
  import ff_load_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  parameter int HOLD_CYC = 2
) (
  input logic clk,
  input logic rst,
  ff_load_arbiter_if.slave bus
);
  localparam int PW = clog2(NREQ);
  localparam int CW = clog2(HOLD_CYC + 1);
  state_t state, nxt;
  logic [PW-1:0] ptr, g, sel, owner;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] cap;
  logic hit, en;
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[(int'(ptr) + k) % NREQ]) begin
        hit = 1'b1;
        sel = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end
  always_comb begin
    nxt = state == IDLE ? (hit ? LOAD : IDLE) :
          state == LOAD ? (HOLD_CYC == 0 ? IDLE : HOLD) :
          state == HOLD ? (cnt == '0 ? IDLE : HOLD) : IDLE;
    en = state == LOAD && !rst;
    bus.ack = en ? NREQ'(1) << g : '0;
    bus.busy = state != IDLE && !rst;
    bus.owner = owner;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      g <= '0;
      cap <= '0;
      cnt <= '0;
      owner <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && hit) begin
        g <= sel;
        cap <= bus.wdata[sel*WIDTH +: WIDTH];
      end
      if (state == LOAD) begin
        owner <= g;
        ptr <= (g == PW'(NREQ - 1)) ? '0 : g + 1'b1;
        cnt <= CW'(HOLD_CYC > 0 ? HOLD_CYC - 1 : 0);
      end
      if (state == HOLD) cnt <= cnt - 1'b1;
    end
  end
  ff_en_reg #(.WIDTH(WIDTH)) u_reg (.clk(clk), .rst(rst), .d(cap), .en(en), .q(bus.q));
endmodule

// File: tb/tb_ff_load_arbiter.sv
// tb_ff_load_arbiter: directed and random checks of two arbiter instances against a scheduling model
module tb_ff_load_arbiter;
  import ff_load_arbiter_pkg::*;
  localparam int N = 4, W = 8, PW = clog2(N);
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  ff_load_arbiter_if #(.NREQ(N), .WIDTH(W)) b0();
  ff_load_arbiter_if #(.NREQ(N), .WIDTH(W)) b1();
  ff_load_arbiter #(.NREQ(N), .WIDTH(W), .HOLD_CYC(2)) d0(.clk(clk), .rst(rst), .bus(b0));
  ff_load_arbiter #(.NREQ(N), .WIDTH(W), .HOLD_CYC(0)) d1(.clk(clk), .rst(rst), .bus(b1));
  int n_chk = 0, n_fail = 0;
  int hold[2] = '{2, 0};
  int m_ptr[2] = '{0, 0}, m_owner[2] = '{0, 0}, m_grant[2] = '{-1, -1}, m_lock[2] = '{0, 0};
  logic [W-1:0] m_q[2], m_cap[2];
  logic [N-1:0] rq[2];
  logic [N*W-1:0] wd[2];
  assign b0.req = rq[0];
  assign b0.wdata = wd[0];
  assign b1.req = rq[1];
  assign b1.wdata = wd[1];
  function automatic int pick(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_ptr[i] = 0; m_owner[i] = 0; m_q[i] = '0; m_cap[i] = '0; m_grant[i] = -1; m_lock[i] = 0;
      end else if (m_grant[i] >= 0) begin
        m_q[i] = m_cap[i];
        m_owner[i] = m_grant[i];
        m_ptr[i] = (m_grant[i] + 1) % N;
        m_lock[i] = hold[i];
        m_grant[i] = -1;
      end else if (m_lock[i] > 0) begin
        m_lock[i]--;
      end else begin
        int gi;
        gi = pick(m_ptr[i], rq[i]);
        if (gi >= 0) begin
          m_grant[i] = gi;
          m_cap[i] = wd[i][gi*W +: W];
        end
      end
    end
  endtask
  task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_one(input string tag, input int i, input logic [N-1:0] a, input logic bz,
                         input logic [W-1:0] qq, input logic [PW-1:0] ow);
    logic [N-1:0] ea;
    logic eb;
    ea = '0;
    if (m_grant[i] >= 0 && !rst) ea[m_grant[i]] = 1'b1;
    eb = !rst && (m_grant[i] >= 0 || m_lock[i] > 0);
    expect_val({tag, $sformatf("/%0d ack", i)}, 32'(a), 32'(ea));
    expect_val({tag, $sformatf("/%0d busy", i)}, 32'(bz), 32'(eb));
    expect_val({tag, $sformatf("/%0d q", i)}, 32'(qq), 32'(m_q[i]));
    expect_val({tag, $sformatf("/%0d owner", i)}, 32'(ow), 32'(m_owner[i]));
  endtask
  task automatic chk_all(input string tag);
    chk_one(tag, 0, b0.ack, b0.busy, b0.q, b0.owner);
    chk_one(tag, 1, b1.ack, b1.busy, b1.q, b1.owner);
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_all(tag);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      m_q[i] = '0; m_cap[i] = '0; rq[i] = '0; wd[i] = '0;
    end
    for (int c = 0; c < 3; c++) begin
      rq[0] = N'($urandom); rq[1] = N'($urandom);
      wd[0] = {$urandom}; wd[1] = {$urandom};
      step("reset");
    end
    rst = 1'b0; rq[0] = '0; rq[1] = '0;
    step("post_reset");
    rq[0] = 4'b0100; wd[0] = 32'h005A_0000;
    step("rst_grant");
    rst = 1'b1; rq[0] = '0;
    #1;
    chk_all("rst_in_load");
    step("rst_edge");
    rst = 1'b0;
    step("rst_release");
    expect_val("rst_q_zero", 32'(b0.q), 32'h0);
    rq[0] = 4'b0010; wd[0] = {8'h00, 8'h00, 8'hA5, 8'h00};
    rq[1] = 4'b0011; wd[1] = {8'h00, 8'h00, 8'h77, 8'h66};
    step("sl_grant");
    rq[0] = '0;
    for (int c = 0; c < 4; c++) begin
      step("sl_run");
      if (c == 0) begin
        expect_val("sl_q", 32'(b0.q), 32'hA5);
        expect_val("sl_owner", 32'(b0.owner), 32'd1);
      end
    end
    rst = 1'b1;
    step("rr_reset");
    rst = 1'b0;
    rq[0] = 4'b1111; wd[0] = {8'h43, 8'h32, 8'h21, 8'h10};
    for (int c = 0; c < 15; c++) begin
      step("rr");
      if (c == 13) expect_val("rr_q3", 32'(b0.q), 32'h43);
    end
    rq[0] = 4'b1001;
    for (int c = 0; c < 8; c++) begin
      step("wrap");
      if (c == 1) expect_val("wrap_ack0", 32'(b0.ack), 32'b0001);
      if (c == 5) expect_val("wrap_ack3", 32'(b0.ack), 32'b1000);
    end
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) begin
        rq[0] = N'($urandom); rq[1] = N'($urandom);
        wd[0] = {$urandom}; wd[1] = {$urandom};
      end
      step("random");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ff_load_arbiter.md
Name: ff_load_arbiter

Overview:
- Round-robin write arbiter and sequencer for a shared enable-gated flip-flop register.
- NREQ requesters compete to load a WIDTH-bit value. The block grants one requester at a time and drives the register's clock-enable for exactly one cycle.
- After each load it enforces a programmable hold window before re-arbitrating.
- Sits between producer blocks and the shared state register; the register is instantiated inside this block.

Parameters:
- NREQ, 4, number of requesters (>= 2).
- WIDTH, 8, register data width.
- HOLD_CYC, 2, idle cycles enforced after each load before next arbitration (>= 0).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  NREQ  per-requester load request; bit i = requester i.
- wdata  input  NREQ*WIDTH  requester data; slice [i*WIDTH +: WIDTH] = requester i.
- ack  output  NREQ  one-cycle pulse to the requester whose data is being loaded.
- q  output  WIDTH  current shared register contents.
- owner  output  clog2(NREQ)  index of the last requester loaded.
- busy  output  1  high in LOAD and HOLD states.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, rr pointer=0, ack=0, q=0, owner=0, busy=0, hold counter=0, captured data=0.
- Reset dominance: rst asserted in any cycle overrides every other action in that cycle, including a LOAD in progress. No write occurs, no ack is issued, and q returns to 0.
- FSM states: IDLE, LOAD, HOLD.
- IDLE, no request: stay in IDLE, busy=0.
- IDLE, any req bit set:
  - Select the first set bit at or after the rr pointer, searching upward and wrapping modulo NREQ.
  - Register the grant index g and capture wdata slice g.
  - Next state LOAD.
- LOAD (exactly 1 cycle):
  - Internal register enable=1, loading the captured data.
  - ack[g]=1; all other ack bits 0.
  - At the end of the cycle: q<=captured data, owner<=g, rr pointer<=(g+1) mod NREQ.
  - If HOLD_CYC=0 the next state is IDLE; otherwise load counter=HOLD_CYC-1 and go to HOLD.
- HOLD:
  - Decrement the counter each cycle; go to IDLE when the counter is 0 in that cycle.
  - Exactly HOLD_CYC cycles are spent in HOLD.
  - req is ignored during HOLD.
- Latency:
  - req seen in IDLE at cycle t -> ack at t+1 -> q valid at t+2.
  - Steady-state grant period = HOLD_CYC+2 cycles.
- Requester contract: hold req and wdata until ack is seen.
  - Data is captured at grant, so wdata changes or a req drop after the grant cycle do not affect the load; ack is still pulsed.
  - req still high in the cycle after ack counts as a new request.
- Simultaneous requests are resolved solely by the rr pointer. There is no fixed priority, so starvation is impossible.
- Pointer wrap: after grant NREQ-1 the pointer becomes 0.
- Register behaviour: q changes only on the LOAD-cycle edge or on reset; otherwise q holds its value.
- Widths: pointer and owner are clog2(NREQ) bits; the counter is clog2(HOLD_CYC+1) bits, minimum 1; all index arithmetic is modulo NREQ.

Decomposition:
- Shared package: the state encoding (IDLE=2'd0, LOAD=2'd1, HOLD=2'd2) and a clog2 function/constant.
- One sub-module, ff_en_reg: a WIDTH-bit register with synchronous active-high reset and clock-enable, exposing only d, en and q.
- The arbiter FSM, rr search and hold counter live in ff_load_arbiter.

Test Plan:
- Reset: hold rst high 3 cycles with random req/wdata -> ack=0, q=0x00, owner=0, busy=0 throughout, and on the first cycle after release.
- Single load (NREQ=4, WIDTH=8, HOLD_CYC=2): req[1]=1, wdata[1]=0xA5 at cycle t, dropped after ack -> ack=4'b0010 at t+1 only; q=0xA5 and owner=1 from t+2; busy high t+1..t+3; IDLE at t+4.
- Round-robin fairness: req=4'b1111 held, data 0x10/0x21/0x32/0x43 -> acks to 0,1,2,3 at t+1, t+5, t+9, t+13; q follows 0x10, 0x21, 0x32, 0x43.
- Pointer wrap: after the grant to 3, req=4'b1001 -> next ack goes to requester 0, not 3; the next grant after that goes to 3.
- Reset mid-operation: rst asserted in the LOAD cycle of a req[2]=1, wdata=0x5A load -> no ack pulse, q stays 0x00, state IDLE, pointer 0 after release.
- Zero-hold instance (HOLD_CYC=0): req=4'b0011 held -> acks alternate 0,1,0,1 with period 2 cycles, and busy toggles 0/1.
